// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one external ALU through an IDLE/ISSUE/WAIT/DONE sequence.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; the default build uses fixed priority (requester 0 wins).
module alu_arbiter #(
   parameter int unsigned MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [2:0]  op0,
   input  logic [2:0]  op1,
   input  logic [15:0] a0,
   input  logic [15:0] b0,
   input  logic [15:0] a1,
   input  logic [15:0] b1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [15:0] result,
   output logic        z_out,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [2:0]  alu_sel,
   input  logic [15:0] alu_out,
   input  logic        alu_z,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_ZERO = 3'b101;
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

   state_t      state;
   logic [3:0]  cnt;
   logic        owner;
   logic [2:0]  op_q;
   logic        win;
   logic [2:0]  win_op;
   logic [15:0] win_a;
   logic [15:0] win_b;

`ifdef ALU_ARBITER_RR_EN
   // favour names the requester that wins a tie; it points away from the last grant.
   logic favour;

   always_comb begin
      win = 1'b0;
      if (req0 && req1) win = favour;
      else              win = req1;
   end
`else
   always_comb begin
      win = !req0;
   end
`endif

   assign win_op = win ? op1 : op0;
   assign win_a  = win ? a1  : a0;
   assign win_b  = win ? b1  : b0;

   // NOTE: all state, including the result register and the ALU drive, is reset
   // asynchronously and updated only with non-blocking assignments.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         owner   <= 1'b0;
         op_q    <= '0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         result  <= '0;
         z_out   <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         busy    <= 1'b0;
`ifdef ALU_ARBITER_RR_EN
         favour  <= 1'b0;
`endif
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  gnt0    <= !win;
                  gnt1    <= win;
                  owner   <= win;
                  op_q    <= win_op;
                  // Reserved codes 110/111 never reach the ALU.
                  alu_sel <= (win_op > OP_ZERO) ? OP_ZERO : win_op;
                  alu_a   <= win_a;
                  alu_b   <= win_b;
                  busy    <= 1'b1;
                  state   <= ISSUE;
`ifdef ALU_ARBITER_RR_EN
                  favour  <= !win;
`endif
               end
            end
            ISSUE: begin
               cnt   <= (op_q == OP_MUL) ? MUL_CNT : 4'd0;
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == 4'd0) state <= DONE;
               else             cnt   <= cnt - 4'd1;
            end
            DONE: begin
               result <= (op_q > OP_ZERO) ? 16'd0 : alu_out;
               z_out  <= (op_q == OP_ADD || op_q == OP_SUB) ? alu_z : 1'b0;
               done0  <= !owner;
               done1  <= owner;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: behavioural ALU, scoreboard queue of expected completions.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, req1;
   logic [2:0]  op0, op1;
   logic [15:0] a0, b0, a1, b1;
   logic        gnt0, gnt1, done0, done1;
   logic [15:0] result;
   logic        z_out;
   logic [15:0] alu_a, alu_b;
   logic [2:0]  alu_sel;
   logic [15:0] alu_out;
   logic        alu_z;
   logic        busy;

   typedef struct {
      logic        who;
      logic [15:0] res;
      logic        z;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   alu_arbiter #(.MUL_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .op0(op0), .op1(op1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .z_out(z_out),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_z(alu_z), .busy(busy)
   );

   always #5 clk = ~clk;

   // External shared ALU.
   always_comb begin
      alu_out = '0;
      case (alu_sel)
         3'd0: alu_out = alu_a + alu_b;
         3'd1: alu_out = alu_a - alu_b;
         3'd2: alu_out = 16'(alu_a * alu_b);
         3'd3: alu_out = alu_a;
         3'd4: alu_out = alu_b;
         default: alu_out = '0;
      endcase
   end
   assign alu_z = (alu_out == 16'd0);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed=timeout expected=event", tag);
   endtask

   function automatic logic [15:0] model_res(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return 16'(a * b);
         3'd3: return a;
         3'd4: return b;
         default: return 16'd0;
      endcase
   endfunction

   function automatic exp_t model(input logic who, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      e.who = who;
      e.res = model_res(op, a, b);
      e.z   = (op <= 3'd1) && (e.res == 16'd0);
      return e;
   endfunction

   task automatic wait_gnt(output int who);
      who = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            who = gnt1 ? 1 : 0;
            break;
         end
      end
      if (who < 0) timeout("gnt_wait");
      else check("gnt_exclusive", {31'd0, gnt0 & gnt1}, 32'd0);
   endtask

   // Counts cycles from the grant cycle to the done cycle; optionally checks alu_sel holds.
   task automatic wait_done(input bit chk_sel, input logic [2:0] sel_exp, output int lat);
      bit seen = 0;
      lat = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         lat++;
         if (chk_sel) check("alu_sel_stable", {29'd0, alu_sel}, {29'd0, sel_exp});
         if (done0 || done1) begin
            seen = 1;
            break;
         end
      end
      if (!seen) timeout("done_wait");
      else check("done_exclusive", {31'd0, done0 & done1}, 32'd0);
   endtask

   task automatic score_done();
      exp_t e;
      if (sb.size() == 0) begin
         timeout("scoreboard_empty");
         return;
      end
      e = sb.pop_front();
      check("done_owner", {31'd0, done1}, {31'd0, e.who});
      check("result", {16'd0, result}, {16'd0, e.res});
      check("z_out", {31'd0, z_out}, {31'd0, e.z});
   endtask

   task automatic run_op(input logic who, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input bit chk_sel);
      int w, lat;
      logic [2:0] sel_exp;
      sel_exp = (op > 3'd5) ? 3'd5 : op;
      if (who) begin req1 = 1; op1 = op; a1 = a; b1 = b; end
      else     begin req0 = 1; op0 = op; a0 = a; b0 = b; end
      wait_gnt(w);
      check("gnt_who", 32'(w), {31'd0, who});
      check("busy_on_gnt", {31'd0, busy}, 32'd1);
      check("alu_sel", {29'd0, alu_sel}, {29'd0, sel_exp});
      check("alu_a", {16'd0, alu_a}, {16'd0, a});
      check("alu_b", {16'd0, alu_b}, {16'd0, b});
      req0 = 0;
      req1 = 0;
      sb.push_back(model(who, op, a, b));
      wait_done(chk_sel, sel_exp, lat);
      check("latency", 32'(lat), (op == 3'd2) ? 32'd5 : 32'd3);
      score_done();
   endtask

   initial begin
      int  w, lat;
      bit  stray;
      rst_n = 0;
      req0 = 0; req1 = 0; op0 = 0; op1 = 0;
      a0 = 0; b0 = 0; a1 = 0; b1 = 0;
      #12;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      check("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
      check("rst_result", {16'd0, result}, 32'd0);
      check("rst_z_out", {31'd0, z_out}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      run_op(0, 3'd0, 16'd5, 16'd7, 0);            // 5+7=12
      run_op(1, 3'd1, 16'd9, 16'd9, 0);            // zero difference, z=1
      run_op(0, 3'd0, 16'hFFFF, 16'd1, 0);         // wrap to zero, z=1
      run_op(1, 3'd3, 16'd0, 16'd4, 0);            // pass A of 0, z forced low
      run_op(0, 3'd4, 16'd3, 16'hBEEF, 0);         // pass B
      run_op(1, 3'd2, 16'd300, 16'd3, 1);          // multiply, 900, alu_sel held
      run_op(0, 3'd6, 16'd8, 16'd8, 0);            // reserved op -> zero
      run_op(1, 3'd7, 16'd1, 16'd2, 0);            // reserved op -> zero
      run_op(0, 3'd5, 16'd4, 16'd4, 0);            // explicit zero op

      // A request raised and withdrawn while busy leaves no trace.
      req0 = 1; op0 = 3'd0; a0 = 16'd1; b0 = 16'd1;
      wait_gnt(w);
      req0 = 0;
      sb.push_back(model(0, 3'd0, 16'd1, 16'd1));
      @(negedge clk);
      req1 = 1; op1 = 3'd3; a1 = 16'd77;
      @(negedge clk);
      req1 = 0;
      wait_done(0, 3'd0, lat);
      score_done();
      stray = 0;
      repeat (6) begin
         @(negedge clk);
         if (gnt0 || gnt1 || busy) stray = 1;
      end
      check("dropped_req_ignored", {31'd0, stray}, 32'd0);

      // Fresh reset so the round-robin pointer favours requester 0, then contend for 4 ops.
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      req0 = 1; op0 = 3'd0; a0 = 16'd2;  b0 = 16'd3;
      req1 = 1; op1 = 3'd1; a1 = 16'd10; b1 = 16'd4;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(w);
`ifdef ALU_ARBITER_RR_EN
         check("arb_winner", 32'(w), 32'(k % 2));
`else
         check("arb_winner", 32'(w), 32'd0);
`endif
         if (w == 1) sb.push_back(model(1, op1, a1, b1));
         else        sb.push_back(model(0, op0, a0, b0));
         wait_done(0, 3'd0, lat);
         check("arb_latency", 32'(lat), 32'd3);
         score_done();
         if (k == 3) begin req0 = 0; req1 = 0; end
      end

      // Reset during the WAIT phase of a multiply aborts it silently.
      req0 = 1; op0 = 3'd2; a0 = 16'd300; b0 = 16'd3;
      wait_gnt(w);
      req0 = 0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      rst_n = 0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_result", {16'd0, result}, 32'd0);
      check("abort_alu_sel", {29'd0, alu_sel}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (done0 || done1) stray = 1;
      end
      check("abort_no_done", {31'd0, stray}, 32'd0);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
